// File: rtl/axi_read_arbiter.sv
// Round-robin N-client read arbiter onto a single AXI read channel, one burst in flight.
// Optional performance counters are built when AXI_ARB_PERF_EN is defined.
module axi_read_arbiter #(
  parameter int NUM_CLIENTS    = 3,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int ADDR_WIDTH     = 32,
  parameter int IDX_W          = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_CLIENTS-1:0]          req_valid,
  output logic [NUM_CLIENTS-1:0]          req_ready,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CLIENTS*8-1:0]        req_len,
  input  logic [NUM_CLIENTS*3-1:0]        req_size,
  output logic [NUM_CLIENTS-1:0]          resp_valid,
  input  logic [NUM_CLIENTS-1:0]          resp_ready,
  output logic [AXI_DATA_WIDTH-1:0]       resp_data,
  output logic                            resp_last,
  output logic                            resp_err,
  output logic [3:0]                      arid,
  output logic [ADDR_WIDTH-1:0]           araddr,
  output logic [7:0]                      arlen,
  output logic [2:0]                      arsize,
  output logic [1:0]                      arburst,
  output logic [1:0]                      arlock,
  output logic [3:0]                      arcache,
  output logic [2:0]                      arprot,
  output logic                            arvalid,
  input  logic                            arready,
  input  logic [3:0]                      rid,
  input  logic [AXI_DATA_WIDTH-1:0]       rdata,
  input  logic [1:0]                      rresp,
  input  logic                            rlast,
  input  logic                            rvalid,
  output logic                            rready
`ifdef AXI_ARB_PERF_EN
  ,
  output logic [NUM_CLIENTS*32-1:0]       perf_grant_cnt,
  output logic [31:0]                     perf_wait_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       winner_nxt;
  logic                   found;
  logic                   grant;
  logic [NUM_CLIENTS-1:0] owner_onehot;
  logic                   unused_ok;

  // Search starts at rr_ptr and wraps, so the last winner has lowest priority next time.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CLIENTS;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  assign grant      = (state == IDLE) && found;
  assign winner_nxt = (winner == IDX_W'(NUM_CLIENTS - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      arvalid <= 1'b0;
      rr_ptr  <= '0;
      owner   <= '0;
      araddr  <= '0;
      arlen   <= '0;
      arsize  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner   <= winner;
            araddr  <= req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            arlen   <= req_len[int'(winner)*8 +: 8];
            arsize  <= req_size[int'(winner)*3 +: 3];
            rr_ptr  <= winner_nxt;
            arvalid <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (rvalid && rready && rlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arid    = 4'(owner);
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  // R beats go straight through to the owner; backpressure comes only from the owner.
  assign owner_onehot = NUM_CLIENTS'(1) << owner;
  assign rready       = (state == DATA) && resp_ready[owner];
  assign resp_valid   = ((state == DATA) && rvalid) ? owner_onehot : '0;
  assign resp_data    = rdata;
  assign resp_last    = rlast;
  assign resp_err     = rresp[1] | (rid[IDX_W-1:0] != owner);
  assign unused_ok    = ^{rresp[0], rid};

`ifdef AXI_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_grant_cnt <= '0;
      perf_wait_cnt  <= '0;
    end else begin
      if (grant)
        perf_grant_cnt[int'(winner)*32 +: 32] <= perf_grant_cnt[int'(winner)*32 +: 32] + 32'd1;
      if ((|req_valid) && !(|req_ready))
        perf_wait_cnt <= perf_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: vector table of grant scenarios, AR scoreboard, reset/abort sequences.
module tb_axi_read_arbiter;

  localparam int N  = 3;
  localparam int DW = 128;
  localparam int AW = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*8-1:0]  req_len;
  logic [N*3-1:0]  req_size;
  logic [N-1:0]    resp_valid, resp_ready;
  logic [DW-1:0]   resp_data;
  logic            resp_last, resp_err;
  logic [3:0]      arid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst, arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid, arready;
  logic [3:0]      rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast, rvalid, rready;
`ifdef AXI_ARB_PERF_EN
  logic [N*32-1:0] perf_grant_cnt;
  logic [31:0]     perf_wait_cnt;
`endif

  axi_read_arbiter #(.NUM_CLIENTS(N), .AXI_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IDX_W(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_size(req_size),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_last(resp_last), .resp_err(resp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
`ifdef AXI_ARB_PERF_EN
    , .perf_grant_cnt(perf_grant_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
  );

  always #5 clock = ~clock;

  logic [AW-1:0] cl_addr [N];
  logic [7:0]    cl_len  [N];
  logic [2:0]    cl_size [N];

  always_comb begin
    req_addr = '0;
    req_len  = '0;
    req_size = '0;
    for (int c = 0; c < N; c++) begin
      req_addr[c*AW +: AW] = cl_addr[c];
      req_len[c*8 +: 8]    = cl_len[c];
      req_size[c*3 +: 3]   = cl_size[c];
    end
  end

  typedef struct {
    int            c;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
  } ar_t;
  ar_t sb[$];

  typedef struct {
    logic [N-1:0]  mask;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    int            ar_delay;
    bit            toggle;
    bit            bad_rid;
    bit            bad_resp;
    int            exp_c;
  } vec_t;
  vec_t vt [7];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic reset_dut();
    reset      = 1'b1;
    req_valid  = '0;
    arready    = 1'b0;
    rvalid     = 1'b1;
    rlast      = 1'b0;
    rid        = 4'd0;
    rresp      = 2'b00;
    rdata      = '0;
    resp_ready = '1;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
`ifdef AXI_ARB_PERF_EN
    chk("rst_perf_grant", perf_grant_cnt, 0);
    chk("rst_perf_wait", perf_wait_cnt, 0);
`endif
    reset      = 1'b0;
    rvalid     = 1'b0;
    resp_ready = '0;
  endtask

  // Called at a negedge with the DUT idle and the expected winner's request already driven.
  task automatic run_burst(input int exp_c, input int ar_delay, input bit toggle,
                           input bit bad_rid, input bit bad_resp, input bit keep,
                           input int abort_after);
    ar_t e;
    ar_t a;
    int  b;
    int  cyc;
    bit  done;
    #1;
    chk("grant_req_ready", req_ready, N'(1) << exp_c);
    a.c = exp_c; a.addr = cl_addr[exp_c]; a.len = cl_len[exp_c]; a.size = cl_size[exp_c];
    sb.push_back(a);
    @(negedge clock);
    if (!keep) req_valid[exp_c] = 1'b0;
    arready = 1'b0;
    #1;
    chk("arvalid_rise", arvalid, 1);
    chk("addr_no_ready", req_ready, 0);
    for (int i = 0; i < ar_delay; i++) begin
      @(negedge clock);
      #1;
      chk("arvalid_hold", arvalid, 1);
      chk("araddr_hold", araddr, sb[0].addr);
      chk("hold_no_ready", req_ready, 0);
    end
    arready = 1'b1;
    #1;
    e = sb.pop_front();
    chk("arid", arid, 4'(e.c));
    chk("araddr", araddr, e.addr);
    chk("arlen", arlen, e.len);
    chk("arsize", arsize, e.size);
    chk("arburst", arburst, 2'b01);
    @(negedge clock);
    arready = 1'b0;
    b = 0; cyc = 0; done = 1'b0;
    while (!done && b <= int'(e.len) && cyc < 64) begin
      if (b == abort_after) begin
        reset = 1'b1;
        @(negedge clock);
        #1;
        chk("abort_rready", rready, 0);
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_arvalid", arvalid, 0);
`ifdef AXI_ARB_PERF_EN
        chk("abort_perf_grant", perf_grant_cnt, 0);
        chk("abort_perf_wait", perf_wait_cnt, 0);
`endif
        reset = 1'b0;
        done  = 1'b1;
      end else begin
        rvalid = 1'b1;
        rdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
        rlast  = (b == int'(e.len));
        rid    = bad_rid ? 4'((e.c + 2) % N) : 4'(e.c);
        rresp  = bad_resp ? 2'b10 : 2'b00;
        resp_ready = '1;
        resp_ready[e.c] = toggle ? ~cyc[0] : 1'b1;
        #1;
        chk("rready", rready, resp_ready[e.c]);
        chk("resp_valid", resp_valid, N'(1) << e.c);
        chk("resp_data", resp_data, rdata);
        chk("resp_last", resp_last, (b == int'(e.len)));
        chk("resp_err", resp_err, bad_rid | bad_resp);
        chk("data_arvalid", arvalid, 0);
        if (resp_ready[e.c]) b++;
        cyc++;
        @(negedge clock);
      end
    end
    if (!done && b <= int'(e.len)) chk("beat_timeout", b, int'(e.len) + 1);
    rvalid     = 1'b0;
    rlast      = 1'b0;
    resp_ready = '0;
  endtask

  initial begin
    int k;
    for (int c = 0; c < N; c++) begin
      cl_addr[c] = '0; cl_len[c] = '0; cl_size[c] = '0;
    end
    //        mask    addr           len    size  dly tog brid bresp exp
    vt[0] = '{3'b010, 32'h1C000000, 8'd3, 3'd4, 0, 0, 0, 0, 1};
    vt[1] = '{3'b001, 32'h20000100, 8'd0, 3'd2, 5, 0, 0, 0, 0};
    vt[2] = '{3'b101, 32'h30000200, 8'd3, 3'd3, 1, 1, 0, 0, 2};
    vt[3] = '{3'b000, 32'h00000000, 8'd0, 3'd0, 0, 0, 1, 0, 0};
    vt[4] = '{3'b010, 32'h40000400, 8'd1, 3'd4, 2, 0, 0, 1, 1};
    vt[5] = '{3'b011, 32'h50000500, 8'd2, 3'd4, 0, 0, 0, 0, 0};
    vt[6] = '{3'b000, 32'h00000000, 8'd0, 3'd0, 0, 1, 0, 0, 1};

    reset_dut();
    for (int i = 0; i < 7; i++) begin
      k = 0;
      for (int c = 0; c < N; c++) begin
        if (vt[i].mask[c]) begin
          cl_addr[c]   = vt[i].addr + 32'(k) * 32'h40;
          cl_len[c]    = vt[i].len;
          cl_size[c]   = vt[i].size;
          req_valid[c] = 1'b1;
          k++;
        end
      end
      run_burst(vt[i].exp_c, vt[i].ar_delay, vt[i].toggle, vt[i].bad_rid,
                vt[i].bad_resp, 1'b0, -1);
    end

    // Reset in the middle of a burst, then confirm the pointer restarted at client 0.
    reset_dut();
    cl_addr[0] = 32'h60000000; cl_len[0] = 8'd3; cl_size[0] = 3'd4;
    req_valid  = 3'b001;
    run_burst(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    cl_addr[0] = 32'h61000000; cl_len[0] = 8'd0;
    cl_addr[1] = 32'h62000000; cl_len[1] = 8'd0; cl_size[1] = 3'd1;
    req_valid  = 3'b011;
    run_burst(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    req_valid  = '0;
    @(negedge clock);

    // All clients requesting continuously from reset.
    reset_dut();
    for (int c = 0; c < N; c++) begin
      cl_addr[c] = 32'h70000000 + 32'(c) * 32'h1000;
      cl_len[c]  = 8'd1;
      cl_size[c] = 3'(c + 2);
    end
    req_valid = '1;
    for (int i = 0; i < 6; i++) run_burst(i % N, 0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    req_valid = '0;
    repeat (2) @(negedge clock);
    #1;
    chk("final_idle_arvalid", arvalid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
